// File: rtl/lsq_mem_unit_pkg.sv
// Shared LSQ op encodings, FSM states and access-decoding helpers for the
// data-memory access unit.
package lsq_mem_unit_pkg;

  localparam int LSQ_OP_WIDTH = 4;

  typedef enum logic [LSQ_OP_WIDTH-1:0] {
    LSQ_OP_NONE = 4'b0000,
    LSQ_OP_LB   = 4'b0001,
    LSQ_OP_LH   = 4'b0010,
    LSQ_OP_LW   = 4'b0011,
    LSQ_OP_LBU  = 4'b0100,
    LSQ_OP_LHU  = 4'b0101,
    LSQ_OP_SB   = 4'b1001,
    LSQ_OP_SH   = 4'b1010,
    LSQ_OP_SW   = 4'b1011
  } lsq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Misaligned or illegal accesses both retire as "fault": ready + misalign, no RAM effect.
  function automatic logic access_fault(input logic [LSQ_OP_WIDTH-1:0] op,
                                        input logic [1:0] lane);
    case (op)
      LSQ_OP_LB, LSQ_OP_LBU, LSQ_OP_SB: access_fault = 1'b0;
      LSQ_OP_LH, LSQ_OP_LHU, LSQ_OP_SH: access_fault = lane[0];
      LSQ_OP_LW, LSQ_OP_SW:             access_fault = (lane != 2'b00);
      default:                          access_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [LSQ_OP_WIDTH-1:0] op,
                                             input logic [1:0] lane);
    case (op)
      LSQ_OP_SB: byte_enable = 4'b0001 << lane;
      LSQ_OP_SH: byte_enable = 4'b0011 << {lane[1], 1'b0};
      LSQ_OP_SW: byte_enable = 4'b1111;
      default:   byte_enable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsq_mem_unit_dmem_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered (1-cycle) read port.
module lsq_mem_unit_dmem_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  // NOTE: storage has no reset on purpose; clearing a RAM array would force it into flops.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata <= r_mem[i_idx];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/lsq_mem_unit.sv
// Data-memory access unit downstream of the LSQ: fixed-latency access FSM,
// byte-lane store masking and load sign/zero extension.
module lsq_mem_unit
  import lsq_mem_unit_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rollback,
  input  logic [LSQ_OP_WIDTH-1:0] op_in,
  input  logic [31:0]             addr_in,
  input  logic [31:0]             wr_data_in,
  output logic                    busy,
  output logic                    mem_rd_ready,
  output logic [31:0]             mem_rd_data,
  output logic                    mem_wr_ready,
  output logic                    misalign
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [LSQ_OP_WIDTH-1:0] r_op;
  logic [AW+1:0]           r_addr;
  logic [31:0]             r_wdata;
  logic                    r_fault;
  logic [31:0]             r_rd_hold;

  logic        w_accept, w_is_store, w_load_abort, w_ram_en;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_wdata, w_ram_rdata, w_load_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_addr;

  assign w_unused_addr = ^addr_in[31:AW+2];
  assign w_is_store    = r_op[LSQ_OP_WIDTH-1];
  assign w_accept      = (r_state == ST_IDLE) && (op_in != '0) && !rollback;
  assign w_load_abort  = rollback && !w_is_store;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: assign the default first so every path drives w_state_nxt and no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_load_abort)      w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)  w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_fault   <= 1'b0;
      r_rd_hold <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
        r_op    <= op_in;
        r_addr  <= addr_in[AW+1:0];
        r_wdata <= wr_data_in;
        r_fault <= access_fault(op_in, addr_in[1:0]);
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (mem_rd_ready) r_rd_hold <= w_load_ext;
    end
  end

  // RAM is touched only in the last WAIT cycle; rst in that cycle must block the write.
  assign w_ram_en = (r_state == ST_WAIT) && (r_cnt == '0) && !rst && !w_load_abort;
  assign w_ram_we = (w_is_store && !r_fault) ? byte_enable(r_op, r_addr[1:0]) : 4'b0000;

  always_comb begin
    w_ram_wdata = r_wdata;
    case (r_op)
      LSQ_OP_SB: w_ram_wdata = {4{r_wdata[7:0]}};
      LSQ_OP_SH: w_ram_wdata = {2{r_wdata[15:0]}};
      default:   w_ram_wdata = r_wdata;
    endcase
  end

  lsq_mem_unit_dmem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_idx   (r_addr[AW+1:2]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_byte = w_ram_rdata[8*r_addr[1:0] +: 8];
  assign w_half = w_ram_rdata[16*r_addr[1] +: 16];

  always_comb begin
    w_load_ext = '0;
    if (!r_fault) begin
      case (r_op)
        LSQ_OP_LB:  w_load_ext = {{24{w_byte[7]}}, w_byte};
        LSQ_OP_LBU: w_load_ext = {24'h0, w_byte};
        LSQ_OP_LH:  w_load_ext = {{16{w_half[15]}}, w_half};
        LSQ_OP_LHU: w_load_ext = {16'h0, w_half};
        LSQ_OP_LW:  w_load_ext = w_ram_rdata;
        default:    w_load_ext = '0;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign mem_rd_ready = (r_state == ST_RESP) && !w_is_store && !rollback;
  assign mem_wr_ready = (r_state == ST_RESP) && w_is_store;
  assign misalign     = (mem_rd_ready || mem_wr_ready) && r_fault;
  assign mem_rd_data  = mem_rd_ready ? w_load_ext : r_rd_hold;

endmodule

// File: tb/tb_lsq_mem_unit.sv
// Directed scoreboard bench for lsq_mem_unit: sizing, extension, misalignment,
// illegal ops, address wrap, rollback and mid-access reset.
module tb_lsq_mem_unit;
  import lsq_mem_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rollback;
  logic [3:0]  op_in;
  logic [31:0] addr_in, wr_data_in;
  logic        busy, mem_rd_ready, mem_wr_ready, misalign;
  logic [31:0] mem_rd_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_store;
    logic        mis;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsq_mem_unit #(.MEM_WORDS(1024), .MEM_LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rollback     (rollback),
    .op_in        (op_in),
    .addr_in      (addr_in),
    .wr_data_in   (wr_data_in),
    .busy         (busy),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_ready (mem_wr_ready),
    .misalign     (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request pulse; returns at the negedge after it was sampled (cycle T+1).
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    check("idle_before_req", {31'h0, busy}, 32'h0);
    op_in      = op;
    addr_in    = addr;
    wr_data_in = data;
    @(negedge clk);
    op_in      = '0;
    addr_in    = '0;
    wr_data_in = '0;
  endtask

  task automatic push(input logic st, input logic mis, input logic [31:0] data,
                      input string tag);
    exp_t e;
    e.is_store = st;
    e.mis      = mis;
    e.data     = data;
    e.tag      = tag;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the next ready pulse and compare it with the scoreboard head.
  task automatic wait_resp(input int start_cyc);
    exp_t e;
    int   cyc = start_cyc;
    e = sb_q.pop_front();
    while (!(mem_rd_ready || mem_wr_ready) && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check({e.tag, "_latency"}, cyc, 3);
    check({e.tag, "_rd_ready"}, {31'h0, mem_rd_ready}, {31'h0, !e.is_store});
    check({e.tag, "_wr_ready"}, {31'h0, mem_wr_ready}, {31'h0, e.is_store});
    check({e.tag, "_misalign"}, {31'h0, misalign}, {31'h0, e.mis});
    if (!e.is_store) check({e.tag, "_data"}, mem_rd_data, e.data);
    @(negedge clk);
    check({e.tag, "_single_pulse"}, {30'h0, mem_rd_ready, mem_wr_ready}, 32'h0);
    check({e.tag, "_busy_clear"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic access(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic exp_mis, input string tag);
    push(op[3], exp_mis, exp_data, tag);
    send(op, addr, data);
    wait_resp(1);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mem_rd_ready || mem_wr_ready || misalign) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rollback   = 1'b0;
    op_in      = '0;
    addr_in    = '0;
    wr_data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_pulses", {29'h0, mem_rd_ready, mem_wr_ready, misalign}, 32'h0);
    check("rst_rd_data", mem_rd_data, 32'h0);
    rst = 1'b0;

    access(LSQ_OP_SW,  32'h100, 32'h12345678, 32'h0,        1'b0, "sw_100");
    access(LSQ_OP_LW,  32'h100, 32'h0,        32'h12345678, 1'b0, "lw_100");
    access(LSQ_OP_SB,  32'h101, 32'h000000AA, 32'h0,        1'b0, "sb_101");
    check("rd_data_hold", mem_rd_data, 32'h12345678);
    access(LSQ_OP_LBU, 32'h101, 32'h0,        32'h000000AA, 1'b0, "lbu_101");
    access(LSQ_OP_LB,  32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, "lb_101");
    access(LSQ_OP_LW,  32'h100, 32'h0,        32'h1234AA78, 1'b0, "lw_after_sb");
    access(LSQ_OP_SH,  32'h102, 32'h00008001, 32'h0,        1'b0, "sh_102");
    access(LSQ_OP_LH,  32'h102, 32'h0,        32'hFFFF8001, 1'b0, "lh_102");
    access(LSQ_OP_LHU, 32'h102, 32'h0,        32'h00008001, 1'b0, "lhu_102");
    access(LSQ_OP_LW,  32'h100, 32'h0,        32'h8001AA78, 1'b0, "lw_after_sh");

    access(LSQ_OP_LW,  32'h102, 32'h0,        32'h0,        1'b1, "lw_misalign");
    access(LSQ_OP_LH,  32'h103, 32'h0,        32'h0,        1'b1, "lh_misalign");
    access(LSQ_OP_SW,  32'h101, 32'hFFFFFFFF, 32'h0,        1'b1, "sw_misalign");
    access(4'b1100,    32'h100, 32'hFFFFFFFF, 32'h0,        1'b1, "illegal_store");
    access(LSQ_OP_LW,  32'h100, 32'h0,        32'h8001AA78, 1'b0, "lw_unchanged");
    access(4'b0111,    32'h100, 32'h0,        32'h0,        1'b1, "illegal_load");

    access(LSQ_OP_SW,  32'h00001104, 32'h0BADF00D, 32'h0,   1'b0, "sw_wrap");
    access(LSQ_OP_LW,  32'h104, 32'h0,        32'h0BADF00D, 1'b0, "lw_wrap");

    // Load flushed in its first WAIT cycle never responds.
    send(LSQ_OP_LW, 32'h100, 32'h0);
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    check("rb_load_busy", {31'h0, busy}, 32'h0);
    expect_quiet(8, "rb_load_no_pulse");

    // Committed store survives a flush and still reports on time.
    push(1'b1, 1'b0, 32'h0, "rb_store");
    send(LSQ_OP_SW, 32'h200, 32'hDEADBEEF);
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    wait_resp(2);
    access(LSQ_OP_LW, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, "lw_rb_store");

    // Request coincident with rollback in IDLE is dropped.
    @(negedge clk);
    op_in    = LSQ_OP_LW;
    addr_in  = 32'h200;
    rollback = 1'b1;
    @(negedge clk);
    op_in    = '0;
    addr_in  = '0;
    rollback = 1'b0;
    check("rb_idle_drop_busy", {31'h0, busy}, 32'h0);
    expect_quiet(6, "rb_idle_drop_quiet");

    // Reset in the final WAIT cycle of a store: no pulse, no write.
    send(LSQ_OP_SW, 32'h100, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_pulses", {29'h0, mem_rd_ready, mem_wr_ready, misalign}, 32'h0);
    expect_quiet(4, "rst_mid_quiet");
    access(LSQ_OP_LW, 32'h100, 32'h0, 32'h8001AA78, 1'b0, "lw_after_rst");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
